// File: rtl/mdu.sv
// Purpose: EX-stage multiply/divide unit with architectural HI/LO (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Latency: MULT/MULTU busy MULT_CYCLES, DIV/DIVU busy DIV_CYCLES; MTHI/MTLO visible the cycle after Start.
// Backpressure: none internal; mdu_Busy tells the hazard unit to stall, Start while busy is ignored.
//
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset (clears HI/LO/Busy, aborts any operation)
//   mdu_Data1  - rs operand: dividend / multiplicand / MTHI-MTLO source
//   mdu_Data2  - rt operand: divisor / multiplier
//   mdu_Op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved (no effect)
//   mdu_Start  - qualifies mdu_Op for one cycle
//   mdu_Busy   - registered, high while a multiply/divide is in flight
//   mdu_HI     - HI register
//   mdu_LO     - LO register
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mdu_Data1,
  input  logic [31:0] mdu_Data2,
  input  logic [2:0]  mdu_Op,
  input  logic        mdu_Start,
  output logic        mdu_Busy,
  output logic [31:0] mdu_HI,
  output logic [31:0] mdu_LO
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [31:0] MULT_LOAD = 32'(MULT_CYCLES - 1);
  localparam logic [31:0] DIV_LOAD  = 32'(DIV_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;       // only the multi-cycle ops (0-3) are ever latched
  logic [31:0] a_q, a_d;         // latched rs
  logic [31:0] b_q, b_d;         // latched rt
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Arithmetic datapath, fed only from the latched operands so input
  // changes after Start cannot affect the result.
  logic [63:0] prod_u;
  logic [63:0] prod_s;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        div_by_zero;
  logic [31:0] udiv_b, sdiv_b;
  logic [31:0] uq, ur;
  logic [31:0] sq_mag, sr_mag;
  logic [31:0] sq, sr;

  always_comb begin
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    // Low 64 bits of an unsigned product of sign-extended operands equal
    // the two's-complement signed product.
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

    a_neg  = a_q[31];
    b_neg  = b_q[31];
    a_mag  = a_neg ? (32'd0 - a_q) : a_q;
    b_mag  = b_neg ? (32'd0 - b_q) : b_q;

    // A zero divisor is replaced by 1 so the dividers never see x/0; the
    // result is discarded in that case and HI/LO keep their values.
    div_by_zero = (b_q == 32'd0);
    udiv_b      = div_by_zero ? 32'd1 : b_q;
    sdiv_b      = div_by_zero ? 32'd1 : b_mag;

    uq     = a_q / udiv_b;
    ur     = a_q % udiv_b;
    sq_mag = a_mag / sdiv_b;
    sr_mag = a_mag % sdiv_b;

    // Quotient truncates toward zero; remainder takes the dividend's sign.
    // 0x80000000 / -1 naturally wraps to 0x80000000 with remainder 0.
    sq = (a_neg ^ b_neg) ? (32'd0 - sq_mag) : sq_mag;
    sr = a_neg ? (32'd0 - sr_mag) : sr_mag;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (mdu_Start) begin
          case (mdu_Op)
            OP_MULT, OP_MULTU: begin
              state_d = S_RUN;
              cnt_d   = MULT_LOAD;
              op_d    = mdu_Op[1:0];
              a_d     = mdu_Data1;
              b_d     = mdu_Data2;
            end
            OP_DIV, OP_DIVU: begin
              state_d = S_RUN;
              cnt_d   = DIV_LOAD;
              op_d    = mdu_Op[1:0];
              a_d     = mdu_Data1;
              b_d     = mdu_Data2;
            end
            OP_MTHI: hi_d = mdu_Data1;
            OP_MTLO: lo_d = mdu_Data1;
            default: ;  // reserved ops do nothing
          endcase
        end
      end

      S_RUN: begin
        // Start is deliberately not looked at here.
        if (cnt_q == 32'd0) begin
          state_d = S_IDLE;
          case (op_q)
            OP_MULT[1:0]: begin
              hi_d = prod_s[63:32];
              lo_d = prod_s[31:0];
            end
            OP_MULTU[1:0]: begin
              hi_d = prod_u[63:32];
              lo_d = prod_u[31:0];
            end
            OP_DIV[1:0]: begin
              if (!div_by_zero) begin
                hi_d = sr;
                lo_d = sq;
              end
            end
            default: begin  // DIVU
              if (!div_by_zero) begin
                hi_d = ur;
                lo_d = uq;
              end
            end
          endcase
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Busy is decoded straight from the state flop, so it is a registered output.
  assign mdu_Busy = (state_q == S_RUN);
  assign mdu_HI   = hi_q;
  assign mdu_LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Purpose: self-checking bench for mdu with an expectation queue and independent monitor.
// Latency: stimulus and checking run in separate processes, decoupled by queues.
// Backpressure: stimulus waits for mdu_Busy to drop (bounded) before issuing the next op.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] d1 = 32'd0;
  logic [31:0] d2 = 32'd0;
  logic [2:0]  op = 3'd0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset     (reset),
    .mdu_Data1 (d1),
    .mdu_Data2 (d2),
    .mdu_Op    (op),
    .mdu_Start (start),
    .mdu_Busy  (busy),
    .mdu_HI    (hi),
    .mdu_LO    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } done_t;

  typedef struct {
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } snap_t;

  done_t done_q[$];
  string done_n[$];
  snap_t snap_q[$];
  string snap_n[$];

  int checks   = 0;
  int failures = 0;

  logic rst_edge  = 1'b1;
  logic prev_busy = 1'b0;
  int   blen      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expectation for a multi-cycle op: checked when Busy falls.
  task automatic expect_done(input string name, input logic [31:0] h, input logic [31:0] l, input int len);
    done_t d;
    d.hi = h; d.lo = l; d.len = len;
    done_q.push_back(d);
    done_n.push_back(name);
  endtask

  // Expectation for the state visible at the next falling edge.
  task automatic expect_snap(input string name, input logic b, input logic [31:0] h, input logic [31:0] l);
    snap_t s;
    s.busy = b; s.hi = h; s.lo = l;
    snap_q.push_back(s);
    snap_n.push_back(name);
  endtask

  // Reset as seen by the DUT at the last rising edge.
  always @(posedge clk) rst_edge <= reset;

  // Monitor
  always @(negedge clk) begin : monitor
    snap_t s;
    done_t d;
    string nm;
    if (snap_q.size() > 0) begin
      s  = snap_q.pop_front();
      nm = snap_n.pop_front();
      chk({nm, "_busy"}, {31'd0, busy}, {31'd0, s.busy});
      chk({nm, "_hi"}, hi, s.hi);
      chk({nm, "_lo"}, lo, s.lo);
    end
    if (rst_edge) begin
      blen      = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        blen++;
      end else if (prev_busy) begin
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion: busy fell after %0d cycles with no op pending, hi=%h lo=%h", blen, hi, lo);
        end else begin
          d  = done_q.pop_front();
          nm = done_n.pop_front();
          chk({nm, "_busy_len"}, 32'(blen), 32'(d.len));
          chk({nm, "_hi"}, hi, d.hi);
          chk({nm, "_lo"}, lo, d.lo);
        end
        blen = 0;
      end
      prev_busy = busy;
    end
  end

  // Drive an op shortly after a falling edge; it is sampled at the next rising edge.
  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    #1;
    op    = o;
    d1    = a;
    d2    = b;
    start = 1'b1;
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL wait_idle_timeout: busy still %0d after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic op_run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string name, input logic [31:0] h, input logic [31:0] l, input int len);
    drive(o, a, b);
    expect_done(name, h, l, len);
    release_start();
    wait_idle();
  endtask

  task automatic op_snap(input logic [2:0] o, input logic [31:0] a, input string name,
                         input logic [31:0] h, input logic [31:0] l);
    drive(o, a, 32'd0);
    expect_snap(name, 1'b0, h, l);
    release_start();
  endtask

  initial begin
    expect_snap("reset", 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Multiply
    op_run(3'd0, 32'hFFFFFFFE, 32'd3, "mult",  32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    op_run(3'd1, 32'hFFFFFFFE, 32'd3, "multu", 32'h00000002, 32'hFFFFFFFA, 5);

    // Divide
    op_run(3'd2, 32'hFFFFFFF9, 32'd2, "div",  32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    op_run(3'd3, 32'd7,        32'd2, "divu", 32'd1,        32'd3,        10);

    // MTHI/MTLO then divide by zero leaves them untouched
    op_snap(3'd4, 32'h1234, "mthi", 32'h1234, 32'd3);
    op_snap(3'd5, 32'h5678, "mtlo", 32'h1234, 32'h5678);
    op_run(3'd3, 32'd9, 32'd0, "divu_by0", 32'h1234, 32'h5678, 10);
    op_run(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf", 32'd0, 32'h80000000, 10);

    // Start while busy is ignored and operands are held from the start
    drive(3'd0, 32'd3, 32'd4);
    expect_done("mult_ign", 32'd0, 32'd12, 5);
    release_start();
    @(negedge clk);
    drive(3'd5, 32'hDEAD, 32'h77);
    expect_snap("start_while_busy", 1'b1, 32'd0, 32'h80000000);
    release_start();
    wait_idle();

    // Reset mid-divide, also racing an MTHI Start
    op_snap(3'd5, 32'hAAAA, "mtlo2", 32'd0, 32'hAAAA);
    drive(3'd2, 32'd100, 32'd7);
    release_start();
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    op    = 3'd4;
    d1    = 32'h5555;
    start = 1'b1;
    expect_snap("reset_abort", 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    expect_snap("no_late_write", 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    op_run(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max", 32'hFFFFFFFE, 32'd1, 5);

    // Back-to-back: MULT issued in the first idle cycle after DIVU
    op_run(3'd3, 32'd100, 32'd7, "divu2",    32'd2, 32'd14, 10);
    op_run(3'd0, 32'd2,   32'd3, "mult_b2b", 32'd0, 32'd6,  5);

    // Reserved op has no effect
    drive(3'd6, 32'hFFFF, 32'hFFFF);
    expect_snap("reserved", 1'b0, 32'd0, 32'd6);
    release_start();
    #1;
    expect_snap("reserved_after", 1'b0, 32'd0, 32'd6);
    @(negedge clk);
    repeat (3) @(negedge clk);

    checks++;
    if (done_q.size() != 0 || snap_q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations: done=%0d snap=%0d left, required 0", done_q.size(), snap_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
